// File: rtl/reset_sequencer.sv
// Staggered reset release for NUM_DOMAINS domains, one step every STEP_CYCLES clocks; board button restarts it.
// Optional RST_SEQ_SYNC_EN: two-flop synchronizer on PCB_RST (adds 2 cycles of request latency).
module reset_sequencer #(
   parameter int NUM_DOMAINS = 4,
   parameter int STEP_CYCLES = 100_000
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   PCB_RST,
   output logic [NUM_DOMAINS-1:0] domain_rst,
   output logic                   busy,
   output logic                   done
);
   // state | meaning
   // HOLD  | step counter running, domains released one per step from bit 0
   // DONE  | all domains released, waiting for a button falling edge
   typedef enum logic {HOLD = 1'b0, DONE = 1'b1} state_t;

   localparam int CW = $clog2(STEP_CYCLES);
   localparam int IW = $clog2(NUM_DOMAINS);
   localparam logic [CW-1:0] RELOAD   = CW'(STEP_CYCLES - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DOMAINS - 1);

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [NUM_DOMAINS-1:0] dom_q, dom_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   button_cur;
   logic                   button_prev_q;
   logic                   button_fall;

`ifdef RST_SEQ_SYNC_EN
   logic sync1_q, sync2_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= PCB_RST;
         sync2_q <= sync1_q;
      end
   end

   assign button_cur = sync2_q;
`else
   assign button_cur = PCB_RST;
`endif

   always_ff @(posedge CLK) begin
      if (RST) button_prev_q <= 1'b1;
      else     button_prev_q <= button_cur;
   end

   assign button_fall = button_prev_q & ~button_cur;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= HOLD;
         cnt_q   <= RELOAD;
         idx_q   <= '0;
         dom_q   <= '1;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         dom_q   <= dom_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      dom_d   = dom_q;
      case (state_q)
         HOLD: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               dom_d[idx_q] = 1'b0;
               cnt_d        = RELOAD;
               if (idx_q == LAST_IDX) state_d = DONE;
               else                   idx_d   = idx_q + 1'b1;
            end
         end
         DONE: begin
            // edges seen during HOLD only update button_prev_q, so nothing is queued
            if (button_fall) begin
               dom_d   = '1;
               cnt_d   = RELOAD;
               idx_d   = '0;
               state_d = HOLD;
            end
         end
         default: state_d = HOLD;
      endcase
      busy_d = |dom_d;
      done_d = ~busy_d;
   end

   assign domain_rst = dom_q;
   assign busy       = busy_q;
   assign done       = done_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (NUM_DOMAINS=4, STEP_CYCLES=10); follows RST_SEQ_SYNC_EN if defined.
module tb_reset_sequencer;
   localparam int ND   = 4;
   localparam int STEP = 10;
`ifdef RST_SEQ_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          PCB_RST = 1'b1;
   logic [ND-1:0] domain_rst;
   logic          busy;
   logic          done;

   int n_chk = 0;
   int n_bad = 0;

   reset_sequencer #(.NUM_DOMAINS(ND), .STEP_CYCLES(STEP)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .PCB_RST   (PCB_RST),
      .domain_rst(domain_rst),
      .busy      (busy),
      .done      (done)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset(input string tag, input int n);
      RST = 1'b1;
      for (int i = 0; i < n; i++) begin
         tick();
         check({tag, "_dom"},  domain_rst, 4'hF);
         check({tag, "_busy"}, busy, 1);
         check({tag, "_done"}, done, 0);
      end
      RST = 1'b0;
   endtask

   // k counts edges after sequence entry; domain i drops at k=(i+1)*STEP
   task automatic seq_check(input string tag, input int kmax, input int pulse_at);
      logic [ND-1:0] full;
      logic [ND-1:0] exp_dom;
      int            rel;
      full = 4'hF;
      for (int k = 1; k <= kmax; k++) begin
         if (k == pulse_at)     PCB_RST = 1'b0;
         if (k == pulse_at + 1) PCB_RST = 1'b1;
         tick();
         rel = k / STEP;
         if (rel > ND) rel = ND;
         exp_dom = full << rel;
         check({tag, "_dom"},  domain_rst, exp_dom);
         check({tag, "_busy"}, busy, (k < ND*STEP) ? 1 : 0);
         check({tag, "_done"}, done, (k < ND*STEP) ? 0 : 1);
      end
   endtask

   task automatic idle_done(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         check({tag, "_dom"},  domain_rst, 0);
         check({tag, "_done"}, done, 1);
      end
   endtask

   task automatic button_req(input string tag);
      PCB_RST = 1'b0;
      for (int i = 0; i < SYNC_LAT; i++) begin
         tick();
         check({tag, "_wait"}, domain_rst, 0);
      end
      tick();
      check({tag, "_assert"}, domain_rst, 4'hF);
      check({tag, "_busy"},   busy, 1);
      check({tag, "_ndone"},  done, 0);
      seq_check(tag, ND*STEP + 5, -1);
   endtask

   initial begin
      // power-on
      do_reset("por_rst", 3);
      seq_check("por", ND*STEP + 5, -1);
      idle_done("por_idle", 5);

      // button request in DONE
      button_req("btn");
      PCB_RST = 1'b1;
      idle_done("btn_idle", 10);

      // reset while in DONE, then a pulse at cycle 15 must be ignored
      do_reset("rst_in_done", 3);
      seq_check("ign", ND*STEP + 5, 15);
      idle_done("ign_idle", 30);

      // button held low through a whole sequence
      PCB_RST = 1'b0;
      do_reset("held_rst", 3);
      seq_check("held", ND*STEP + 5, -1);
      idle_done("held_idle", 20);
      PCB_RST = 1'b1;
      idle_done("held_rel", 4);
      button_req("held_new");
      PCB_RST = 1'b1;
      idle_done("held_new_idle", 5);

      // reset mid-sequence at cycle 25
      do_reset("mid_por", 3);
      seq_check("mid_pre", 25, -1);
      check("mid_pre_dom", domain_rst, 4'hC);
      do_reset("mid_rst", 3);
      seq_check("mid_post", ND*STEP + 5, -1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_DOMAINS, default 4, giving the number of reset domains sequenced (2..8).
REQ-002 The block SHALL have parameter STEP_CYCLES, default 100_000, giving the CLK cycles per sequencing step (20 ms at 5 MHz); minimum 2.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port PCB_RST, input, 1 bit: asynchronous board reset button, active-low; a falling edge requests a reset sequence.
REQ-006 The block SHALL have port domain_rst, output, NUM_DOMAINS bits: active-high per-domain resets; bit 0 is released first.
REQ-007 The block SHALL have port busy, output, 1 bit: high while any domain reset is still asserted.
REQ-008 The block SHALL have port done, output, 1 bit: high once every domain is released; low otherwise.

Function
REQ-009 The FSM SHALL have two states: HOLD (counting and releasing domains) and DONE (all released, watching the button).
REQ-010 HOLD SHALL hold a down-counter (ceil(log2(STEP_CYCLES)) bits) and a domain index (ceil(log2(NUM_DOMAINS)) bits).
REQ-011 In HOLD with counter != 0, the counter SHALL decrement by 1; domain_rst, index and state SHALL be unchanged.
REQ-012 In HOLD with counter == 0, domain_rst[index] SHALL clear to 0 on that edge.
REQ-013 On that same edge, the counter SHALL reload STEP_CYCLES-1 and the index SHALL increment, unless index == NUM_DOMAINS-1.
REQ-014 If index == NUM_DOMAINS-1 on that edge, the state SHALL move to DONE, with busy<=0 and done<=1 on the same edge.
REQ-015 Domain i SHALL therefore be released exactly (i+1)*STEP_CYCLES cycles after HOLD entry; released domains SHALL stay low until the next sequence.
REQ-016 A falling edge SHALL be defined as button_prev == 1 and button_cur == 0, with button_prev a one-cycle delay of button_cur.
REQ-017 A falling edge detected in DONE SHALL, on that edge, set domain_rst to all ones, busy<=1, done<=0, counter<=STEP_CYCLES-1, index<=0 and state<=HOLD.
REQ-018 Falling edges while in HOLD SHALL be ignored: no restart and no queued request.
REQ-019 Button activity during HOLD SHALL not generate a request after entering DONE.
REQ-020 A button held low across a sequence SHALL not retrigger; only a new high-to-low transition seen in DONE counts.
REQ-021 busy SHALL equal the OR of domain_rst, and done SHALL equal NOT busy, at every cycle.
REQ-022 All outputs SHALL be registered; no combinational path SHALL exist from PCB_RST to any output.

Reset
REQ-023 On RST high at a clock edge: domain_rst all ones, busy=1, done=0, state=HOLD, counter=STEP_CYCLES-1, index=0, button_prev=1, synchronizer flops=1.
REQ-024 After RST is released, a power-on sequence SHALL start automatically.
REQ-025 RST asserted during HOLD or DONE SHALL abort the current activity and restart the sequence from domain 0 after RST falls.

Configuration
REQ-026 With RST_SEQ_SYNC_EN defined, PCB_RST SHALL pass through a two-flop synchronizer before forming button_cur, adding exactly 2 cycles to request latency.
REQ-027 Without RST_SEQ_SYNC_EN, button_cur SHALL be PCB_RST sampled directly, and the synchronizer flops SHALL be absent.

Verification (NUM_DOMAINS=4, STEP_CYCLES=10, RST_SEQ_SYNC_EN undefined unless stated)
REQ-028 Power-on: RST high 3 cycles, then low -> domain_rst releases 4'b1111->1110->1100->1000->0000 at 10, 20, 30, 40 cycles after RST low; done=1 at cycle 40.
REQ-029 Button request: in DONE, drive PCB_RST 1->0 -> domain_rst=4'b1111 and busy=1 one edge after the 0 is sampled; full release completes 40 cycles later.
REQ-030 Ignored request: pulse PCB_RST low at cycle 15 of a sequence -> timing identical to REQ-028; no second sequence after done.
REQ-031 Held button: keep PCB_RST low through an entire sequence -> done stays 1 afterward; a later 1->0 edge starts a new sequence.
REQ-032 Mid-sequence reset: assert RST at cycle 25 (domains 0-1 released) -> domain_rst=4'b1111 on the next edge; full sequence restarts after RST low.
REQ-033 Sync build: with RST_SEQ_SYNC_EN defined, repeat REQ-029 -> domain_rst asserts exactly 2 cycles later than in REQ-029.
